// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, DIGIT bits per clock, N = WIDTH/DIGIT cycles per op.
// Ports: clk, rst (sync, active-high); start, sub, in1, in2, cin in; sum, carry, busy, done out.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow output ovf.
// WIDTH must be >= 2 and an integer multiple of DIGIT.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_q;
   logic             carry_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;

   logic [DIGIT-1:0] a_sl;
   logic [DIGIT-1:0] b_sl;
   logic [DIGIT:0]   sl_d;
   logic [WIDTH-1:0] res_d;
   logic             last_d;
   int unsigned      idx;

   // One slice per cycle, selected by the digit counter; the partial
   // result is written slice-by-slice into res so no shifters are needed.
   always_comb begin
      idx    = int'(cnt_q) * DIGIT;
      a_sl   = a_q[idx +: DIGIT];
      b_sl   = b_q[idx +: DIGIT];
      sl_d   = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, c_q};
      res_d  = res_q;
      res_d[idx +: DIGIT] = sl_d[DIGIT-1:0];
      last_d = (cnt_q == CW'(N - 1));
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;
   logic msb_cin;

   // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
   assign msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_d) begin
         ovf_q <= msb_cin ^ sl_d[DIGIT];
      end
   end

   assign ovf = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  // Subtraction as in1 + ~in2 + 1.
                  a_q     <= in1;
                  b_q     <= sub ? ~in2 : in2;
                  c_q     <= sub ? 1'b1 : cin;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               res_q <= res_d;
               c_q   <= sl_d[DIGIT];
               cnt_q <= cnt_q + 1'b1;
               if (last_d) begin
                  sum_q   <= res_d;
                  carry_q <= sl_d[DIGIT];
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sum   = sum_q;
   assign carry = carry_q;
   assign done  = done_q;
   assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder, WIDTH=8 with DIGIT=1 (dut 0) and DIGIT=4 (dut 1).
// A driver pushes expected results; per-dut monitors pop and compare on done.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] start;
   logic [1:0] sub;
   logic [1:0] cin;
   logic [7:0] in1 [2];
   logic [7:0] in2 [2];
   logic [7:0] sum [2];
   logic [1:0] carry;
   logic [1:0] busy;
   logic [1:0] done;
`ifdef SERIAL_ADDER_OVF_EN
   logic [1:0] ovf;
`endif

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d0 (
      .clk(clk), .rst(rst), .start(start[0]), .sub(sub[0]),
      .in1(in1[0]), .in2(in2[0]), .cin(cin[0]),
      .sum(sum[0]), .carry(carry[0]), .busy(busy[0]), .done(done[0])
`ifdef SERIAL_ADDER_OVF_EN
     ,.ovf(ovf[0])
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d1 (
      .clk(clk), .rst(rst), .start(start[1]), .sub(sub[1]),
      .in1(in1[1]), .in2(in2[1]), .cin(cin[1]),
      .sum(sum[1]), .carry(carry[1]), .busy(busy[1]), .done(done[1])
`ifdef SERIAL_ADDER_OVF_EN
     ,.ovf(ovf[1])
`endif
   );

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       v;
      int         cyc;
   } exp_t;

   exp_t q0 [$];
   exp_t q1 [$];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int bcnt [2] = '{0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nsl(int d);
      return (d == 0) ? 8 : 2;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(logic [7:0] s, logic c, logic v);
      exp_t e;
      e.s = s; e.c = c; e.v = v; e.cyc = 0;
      return e;
   endfunction

   // Reference: plain integer arithmetic, two's-complement overflow
   // from operand/result signs.
   function automatic exp_t model(int a, int b, bit s, bit ci);
      int bb, cc, tot;
      exp_t e;
      bb  = s ? ((~b) & 255) : b;
      cc  = s ? 1 : int'(ci);
      tot = a + bb + cc;
      e.s = tot[7:0];
      e.c = tot[8];
      e.v = (a[7] == bb[7]) && (tot[7] != a[7]);
      e.cyc = 0;
      return e;
   endfunction

   task automatic check_done(int d, exp_t e);
      chk($sformatf("sum%0d", d), {24'h0, sum[d]}, {24'h0, e.s});
      chk($sformatf("carry%0d", d), {31'h0, carry[d]}, {31'h0, e.c});
      chk($sformatf("latency%0d", d), cyc, e.cyc);
      chk($sformatf("busy_cycles%0d", d), bcnt[d], nsl(d));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("ovf%0d", d), {31'h0, ovf[d]}, {31'h0, e.v});
`endif
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (done[d] === 1'b1) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done%0d: got done=1, expected none", d);
            end else if (d == 0) begin
               check_done(0, q0.pop_front());
            end else begin
               check_done(1, q1.pop_front());
            end
         end
         if (busy[d] === 1'b1) bcnt[d]++;
         else bcnt[d] = 0;
      end
   end

   // Called at a negedge with the dut idle or in its done cycle;
   // returns at the negedge of the done cycle.
   task automatic run_op(int d, logic [7:0] a, logic [7:0] b, logic s,
                         logic ci, exp_t e, bit mid);
      in1[d] = a; in2[d] = b; sub[d] = s; cin[d] = ci;
      start[d] = 1'b1;
      e.cyc = cyc + 1 + nsl(d);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      @(negedge clk);
      start[d] = 1'b0;
      in1[d] = 8'($urandom); in2[d] = 8'($urandom);
      sub[d] = 1'($urandom); cin[d] = 1'($urandom);
      for (int i = 1; i <= nsl(d); i++) begin
         @(negedge clk);
         if (mid && i == 2) start[d] = 1'b1;
         if (mid && i == 3) start[d] = 1'b0;
      end
   endtask

   task automatic rand_ops(int d, int cnt);
      logic [7:0] a, b;
      logic s, ci;
      for (int k = 0; k < cnt; k++) begin
         a = 8'($urandom); b = 8'($urandom);
         s = 1'($urandom); ci = 1'($urandom);
         if (k % 4 == 0) begin
            a = (k % 8 == 0) ? 8'hFF : 8'h80;
         end
         run_op(d, a, b, s, ci, model(a, b, s, ci), 1'b0);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = '0; sub = '0; cin = '0;
      in1[0] = '0; in1[1] = '0; in2[0] = '0; in2[1] = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_sum%0d", d), {24'h0, sum[d]}, 32'h0);
         chk($sformatf("rst_carry%0d", d), {31'h0, carry[d]}, 32'h0);
         chk($sformatf("rst_busy%0d", d), {31'h0, busy[d]}, 32'h0);
         chk($sformatf("rst_done%0d", d), {31'h0, done[d]}, 32'h0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0), 1'b0);
      run_op(0, 8'h05, 8'h07, 1'b1, 1'b0, mk(8'hFE, 1'b0, 1'b0), 1'b0);
      run_op(0, 8'h07, 8'h05, 1'b1, 1'b1, mk(8'h02, 1'b1, 1'b0), 1'b0);
      @(negedge clk);
      run_op(0, 8'h12, 8'h34, 1'b0, 1'b1, mk(8'h47, 1'b0, 1'b0), 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1), 1'b0);
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0), 1'b0);
`endif
      rand_ops(0, 20);
      run_op(0, 8'h40, 8'h21, 1'b0, 1'b0, mk(8'h61, 1'b0, 1'b0), 1'b0);

      // Abandon an operation three cycles into RUN.
      in1[0] = 8'hAA; in2[0] = 8'h11; sub[0] = 1'b0; cin[0] = 1'b0;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_sum", {24'h0, sum[0]}, 32'h0);
      chk("abort_carry", {31'h0, carry[0]}, 32'h0);
      chk("abort_busy", {31'h0, busy[0]}, 32'h0);
      chk("abort_done", {31'h0, done[0]}, 32'h0);
      repeat (10) @(negedge clk);
      run_op(0, 8'h0F, 8'hF0, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0), 1'b0);
      @(negedge clk);

      run_op(1, 8'h3C, 8'h4B, 1'b0, 1'b1, mk(8'h88, 1'b0, 1'b1), 1'b0);
      run_op(1, 8'h05, 8'h07, 1'b1, 1'b0, mk(8'hFE, 1'b0, 1'b0), 1'b0);
      run_op(1, 8'h80, 8'h01, 1'b1, 1'b0, mk(8'h7F, 1'b1, 1'b1), 1'b0);
      rand_ops(1, 20);

      for (int w = 0; w < 40; w++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(negedge clk);
      end
      while (q0.size() != 0) begin
         void'(q0.pop_front());
         n_cmp++; n_bad++;
         $display("FAIL timeout0: got no done, expected done");
      end
      while (q1.size() != 0) begin
         void'(q1.pop_front());
         n_cmp++; n_bad++;
         $display("FAIL timeout1: got no done, expected done");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
